// File: rtl/custom_inst_dispatch_queue.sv
// Decode-and-dispatch queue for the custom (4'b1111) opcode space: decodes accelerator
// instructions, tags producer/consumer fusion pairs and keeps saturating usage counters.
module custom_inst_dispatch_queue #(
  parameter  int IW    = 16,
  parameter  int NACC  = 3,
  parameter  int DEPTH = 4,
  parameter  int CNTW  = 32,
  localparam int IMW   = IW - 13,
  localparam int AW    = $clog2(DEPTH),
  localparam int OW    = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [IW-1:0]        in_inst_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [1:0]           out_acc_sel_o,
  output logic [3:0]           out_op_o,
  output logic [2:0]           out_rd_o,
  output logic [2:0]           out_rs1_o,
  output logic [IMW-1:0]       out_imm_o,
  output logic                 out_fused_o,
  output logic [1:0]           out_fuse_type_o,
  output logic                 illegal_pulse_o,
  output logic [OW-1:0]        occupancy_o,
  output logic [NACC*CNTW-1:0] acc_count_o,
  output logic [CNTW-1:0]      illegal_count_o
);

  typedef struct packed {
    logic [1:0]     acc;
    logic [3:0]     op;
    logic [2:0]     rd;
    logic [IMW-1:0] imm;
    logic           fused;
    logic [1:0]     ftype;
  } entry_t;

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  entry_t         mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]  occ_q, occ_d;
  logic           trk_vld_q, trk_vld_d;
  logic [1:0]     trk_acc_q, trk_acc_d;
  logic [3:0]     trk_op_q, trk_op_d;
  logic [2:0]     trk_rd_q, trk_rd_d;
  logic [CNTW-1:0] acc_cnt_q [NACC];
  logic [CNTW-1:0] ill_cnt_q;
  logic           ill_pulse_q;

  logic [3:0]     opc_s, op_s;
  logic [1:0]     acc_s, ftype_s;
  logic [2:0]     rd_s, rs1_s;
  logic           custom_s, legal_s, accept_s, push_s, pop_s, illegal_s, fuse_s;
  logic           full_s, empty_s;
  entry_t         head_s, new_s;

  // Field decode; the immediate is {ext, rs1}, i.e. the low IMW bits of the word.
  assign opc_s     = in_inst_i[IW-1 -: 4];
  assign acc_s     = in_inst_i[IW-5 -: 2];
  assign op_s      = in_inst_i[IW-7 -: 4];
  assign rd_s      = in_inst_i[IW-11 -: 3];
  assign rs1_s     = in_inst_i[IW-14 -: 3];
  assign custom_s  = (opc_s == 4'hF);
  assign legal_s   = ({1'b0, acc_s} < 3'(NACC));

  assign full_s    = (occ_q == OW'(DEPTH));
  assign empty_s   = (occ_q == {OW{1'b0}});
  assign in_ready_o = !full_s && !flush_i;
  assign accept_s  = in_valid_i && in_ready_o;
  assign push_s    = accept_s && custom_s && legal_s;
  assign illegal_s = accept_s && custom_s && !legal_s;
  assign pop_s     = !empty_s && out_ready_i && !flush_i;

  // Fusion detection against the last legal pushed instruction.
  always_comb begin
    fuse_s  = trk_vld_q && (trk_acc_q == acc_s) && (rs1_s == trk_rd_q);
    ftype_s = 2'b00;
    if (!fuse_s) begin
      ftype_s = 2'b00;
    end else if (trk_op_q == 4'd0) begin
      ftype_s = 2'b01;
    end else if (op_s == 4'd1) begin
      ftype_s = 2'b10;
    end else begin
      ftype_s = 2'b11;
    end
    new_s = '{acc: acc_s, op: op_s, rd: rd_s, imm: in_inst_i[IMW-1:0],
              fused: fuse_s, ftype: ftype_s};
  end

  // Pointer, occupancy and tracker next state.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    trk_vld_d = trk_vld_q;
    trk_acc_d = trk_acc_q;
    trk_op_d  = trk_op_q;
    trk_rd_d  = trk_rd_q;
    if (flush_i) begin
      wr_ptr_d  = {AW{1'b0}};
      rd_ptr_d  = {AW{1'b0}};
      occ_d     = {OW{1'b0}};
      trk_vld_d = 1'b0;
    end else begin
      wr_ptr_d = push_s ? wr_ptr_q + AW'(1'b1) : wr_ptr_q;
      rd_ptr_d = pop_s ? rd_ptr_q + AW'(1'b1) : rd_ptr_q;
      occ_d    = occ_q + OW'(push_s) - OW'(pop_s);
      if (push_s) begin
        trk_vld_d = 1'b1;
        trk_acc_d = acc_s;
        trk_op_d  = op_s;
        trk_rd_d  = rd_s;
      end else if (accept_s) begin
        trk_vld_d = 1'b0;
      end else begin
        trk_vld_d = trk_vld_q;
      end
    end
  end

  // Control state, tracker and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      occ_q       <= {OW{1'b0}};
      trk_vld_q   <= 1'b0;
      trk_acc_q   <= 2'b00;
      trk_op_q    <= 4'd0;
      trk_rd_q    <= 3'd0;
      ill_cnt_q   <= {CNTW{1'b0}};
      ill_pulse_q <= 1'b0;
      for (int k = 0; k < NACC; k++) acc_cnt_q[k] <= {CNTW{1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      trk_vld_q   <= trk_vld_d;
      trk_acc_q   <= trk_acc_d;
      trk_op_q    <= trk_op_d;
      trk_rd_q    <= trk_rd_d;
      ill_pulse_q <= illegal_s;
      if (illegal_s && ill_cnt_q != CNT_MAX) ill_cnt_q <= ill_cnt_q + CNTW'(1'b1);
      for (int k = 0; k < NACC; k++) begin
        if (push_s && acc_s == 2'(k) && acc_cnt_q[k] != CNT_MAX)
          acc_cnt_q[k] <= acc_cnt_q[k] + CNTW'(1'b1);
      end
    end
  end

  // Queue storage; contents only matter while counted by occupancy.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= new_s;
  end

  assign head_s          = mem_q[rd_ptr_q];
  assign out_valid_o     = !empty_s;
  assign out_acc_sel_o   = empty_s ? 2'b00 : head_s.acc;
  assign out_op_o        = empty_s ? 4'd0 : head_s.op;
  assign out_rd_o        = empty_s ? 3'd0 : head_s.rd;
  assign out_rs1_o       = empty_s ? 3'd0 : head_s.imm[2:0];
  assign out_imm_o       = empty_s ? {IMW{1'b0}} : head_s.imm;
  assign out_fused_o     = empty_s ? 1'b0 : head_s.fused;
  assign out_fuse_type_o = empty_s ? 2'b00 : head_s.ftype;
  assign illegal_pulse_o = ill_pulse_q;
  assign occupancy_o     = occ_q;
  assign illegal_count_o = ill_cnt_q;

  for (genvar k = 0; k < NACC; k++) begin : g_cnt
    assign acc_count_o[k*CNTW +: CNTW] = acc_cnt_q[k];
  end

endmodule

// File: tb/tb_custom_inst_dispatch_queue.sv
// Directed bench for custom_inst_dispatch_queue (IW=16, NACC=3, DEPTH=4, CNTW=4).
module tb_custom_inst_dispatch_queue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_inst;
  logic [1:0]  out_acc_sel, out_fuse_type;
  logic [3:0]  out_op, illegal_count;
  logic [2:0]  out_rd, out_rs1, out_imm, occupancy;
  logic        out_fused, illegal_pulse;
  logic [11:0] acc_count;

  int chk_cnt = 0;
  int err_cnt = 0;

  custom_inst_dispatch_queue #(.IW(16), .NACC(3), .DEPTH(4), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_inst_i(in_inst), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_acc_sel_o(out_acc_sel), .out_op_o(out_op), .out_rd_o(out_rd), .out_rs1_o(out_rs1),
    .out_imm_o(out_imm), .out_fused_o(out_fused), .out_fuse_type_o(out_fuse_type),
    .illegal_pulse_o(illegal_pulse), .occupancy_o(occupancy), .acc_count_o(acc_count),
    .illegal_count_o(illegal_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    in_inst  = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = 16'h0000;
    #22 rst = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_op", out_op, 0);
    check_eq("rst_occ", occupancy, 0);
    check_eq("rst_acc_count", acc_count, 0);
    check_eq("rst_ill_count", illegal_count, 0);
    check_eq("rst_ill_pulse", illegal_pulse, 0);

    // Single push: crypto, op3, rd1, rs1=1.
    push(16'hF0C9);
    check_eq("p1_valid", out_valid, 1);
    check_eq("p1_acc", out_acc_sel, 0);
    check_eq("p1_op", out_op, 3);
    check_eq("p1_rd", out_rd, 1);
    check_eq("p1_rs1", out_rs1, 1);
    check_eq("p1_imm", out_imm, 1);
    check_eq("p1_fused", out_fused, 0);
    check_eq("p1_occ", occupancy, 1);
    check_eq("p1_cnt0", acc_count[3:0], 1);
    pop();
    check_eq("p1_empty", out_valid, 0);
    check_eq("p1_empty_op", out_op, 0);

    // Fill: five AI words (rs1=7, rd=0, no fusion), ops 1..5.
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_inst = 16'hF807 | 16'(i << 6);
      step();
    end
    check_eq("full_ready", in_ready, 0);
    check_eq("full_occ", occupancy, 4);
    in_inst = 16'hF947;
    step();
    check_eq("full_hold_occ", occupancy, 4);
    check_eq("full_hold_ready", in_ready, 0);
    check_eq("full_cnt2", acc_count[11:8], 4);
    out_ready = 1'b1;
    step();
    check_eq("drain1_ready", in_ready, 1);
    check_eq("drain1_occ", occupancy, 3);
    check_eq("drain1_op", out_op, 2);
    step();
    in_valid = 1'b0;
    check_eq("drain2_occ", occupancy, 3);
    check_eq("drain2_op", out_op, 3);
    step();
    check_eq("drain3_op", out_op, 4);
    step();
    check_eq("drain4_op", out_op, 5);
    check_eq("drain4_acc", out_acc_sel, 2);
    step();
    out_ready = 1'b0;
    check_eq("drain_empty", out_valid, 0);
    check_eq("drain_cnt2", acc_count[11:8], 5);

    // Load-fuse pair, then store-fuse and chain.
    push(16'hF008);
    push(16'hF051);
    check_eq("fz_first_fused", out_fused, 0);
    pop();
    check_eq("fz_load_fused", out_fused, 1);
    check_eq("fz_load_type", out_fuse_type, 2'b01);
    pop();
    push(16'hF05A);
    push(16'hF0A3);
    check_eq("fz_store_fused", out_fused, 1);
    check_eq("fz_store_type", out_fuse_type, 2'b10);
    pop();
    check_eq("fz_chain_type", out_fuse_type, 2'b11);
    pop();

    // Non-custom word breaks the pair and is not queued.
    push(16'hF008);
    push(16'h1234);
    push(16'hF051);
    check_eq("nc_occ", occupancy, 2);
    pop();
    check_eq("nc_op", out_op, 1);
    check_eq("nc_fused", out_fused, 0);
    pop();

    // Illegal select.
    push(16'hF008);
    push(16'hFC00);
    check_eq("ill_pulse", illegal_pulse, 1);
    check_eq("ill_count", illegal_count, 1);
    check_eq("ill_occ", occupancy, 1);
    push(16'hF051);
    check_eq("ill_pulse_low", illegal_pulse, 0);
    check_eq("ill_occ2", occupancy, 2);
    pop();
    check_eq("ill_nofuse", out_fused, 0);
    pop();
    check_eq("ill_cnt0", acc_count[3:0], 9);

    // Flush with a word offered and a pop requested.
    push(16'hF008);
    push(16'hF008);
    push(16'hF008);
    check_eq("fl_occ_pre", occupancy, 3);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_inst = 16'hF008;
    #1;
    check_eq("fl_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_eq("fl_occ", occupancy, 0);
    check_eq("fl_valid", out_valid, 0);
    check_eq("fl_cnt0", acc_count[3:0], 12);

    // DSP counter saturation with continuous push/pop.
    out_ready = 1'b1;
    in_inst = 16'hF400;
    in_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      if (i == 14) check_eq("sat_14", acc_count[7:4], 4'hE);
      if (i == 15) check_eq("sat_15", acc_count[7:4], 4'hF);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("sat_17", acc_count[7:4], 4'hF);
    check_eq("sat_occ", occupancy, 1);
    check_eq("sat_cnt0", acc_count[3:0], 12);

    // Asynchronous mid-operation reset.
    #2 rst = 1'b1;
    #1;
    check_eq("arst_occ", occupancy, 0);
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_cnt", acc_count, 0);
    check_eq("arst_ill", illegal_count, 0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
